// File: rtl/desloc_pkg.sv
// Shared types and constants for the desloc serial link (transmitter and shift register).
// Latency: n/a. Backpressure: n/a.
// Holds the FSM state encoding, bit-order constants and the shift-register op codes.
package desloc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef logic [1:0] op_t;

    localparam op_t OP_HOLD = 2'b00;
    localparam op_t OP_SHL  = 2'b01;
    localparam op_t OP_SHR  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;

    // MSB-first frames drain through the top of the register, so they shift left.
    function automatic op_t shift_op(input logic dir);
        return (dir == DIR_LSB_FIRST) ? OP_SHR : OP_SHL;
    endfunction

endpackage

// File: rtl/desloc_shift_core.sv
// WIDTH-bit load/shift register driven by the shared desloc op codes.
// Latency: one cycle per op; next_end_bit previews the end bit after the current op.
// Backpressure: none, the op is applied every cycle.
module desloc_shift_core
    import desloc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  op_t              op,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             end_sel,
    output logic             next_end_bit
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        case (op)
            OP_LOAD: q_nxt = load_dat;
            OP_SHL:  q_nxt = {q[WIDTH-2:0], 1'b0};
            OP_SHR:  q_nxt = {1'b0, q[WIDTH-1:1]};
            default: q_nxt = q;
        endcase
    end

    // Looking at the post-op value lets the caller register the bit it is about to expose.
    assign next_end_bit = (end_sel == DIR_LSB_FIRST) ? q_nxt[0] : q_nxt[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/desloc_ser_tx.sv
// Parallel-in/serial-out transmitter for the desloc link; optional parity bit under DESLOC_PARITY_EN.
// Latency: first bit one cycle after accept, done one cycle after the last frame bit.
// Backpressure: in_ready drops for the frame plus GAP_CYCLES; in_valid is ignored meanwhile.
module desloc_ser_tx
    import desloc_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef DESLOC_PARITY_EN
    localparam int LAST_BIT = WIDTH;
`else
    localparam int LAST_BIT = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BIT);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic             dir_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    op_t              op;
    logic             accept;
    logic             last_bit;
    logic             end_sel;
    logic             next_end_bit;
`ifdef DESLOC_PARITY_EN
    logic             par_q;
`endif

    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == LAST_CNT);
    assign end_sel  = accept ? dir : dir_q;

    always_comb begin
        op = OP_HOLD;
        if (accept) begin
            op = OP_LOAD;
        end else if (state == ST_SHIFT && !last_bit) begin
            op = shift_op(dir_q);
        end
    end

    desloc_shift_core #(
        .WIDTH(WIDTH)
    ) u_shift_core (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .load_dat     (data_in),
        .end_sel      (end_sel),
        .next_end_bit (next_end_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            dir_q        <= DIR_MSB_FIRST;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef DESLOC_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_SHIFT;
                        dir_q        <= dir;
                        bit_cnt      <= '0;
                        serial_out   <= next_end_bit;
                        serial_valid <= 1'b1;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
`ifdef DESLOC_PARITY_EN
                        par_q        <= ^data_in;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        done         <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state    <= ST_GAP;
                            gap_cnt  <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef DESLOC_PARITY_EN
                        // The data bits are exhausted; the trailing bit is the captured parity.
                        serial_out <= (bit_cnt == CNT_W'(WIDTH - 1)) ? par_q : next_end_bit;
`else
                        serial_out <= next_end_bit;
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/desloc_ser_tx.md
Name: desloc_ser_tx

Overview:
- Parallel-in/serial-out transmitter: the sending end of the serial link consumed by the team's universal shift register (`serial_in` port).
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock, MSB-first or LSB-first.
- Marks each frame with `serial_valid` and pulses `done` when the frame ends.
- Sits between a word producer and any `reg_desloc`-style receiver.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- GAP_CYCLES, 0, forced idle cycles after each frame before `in_ready` reasserts (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- dir  input  1  0 = MSB first (shift-left order), 1 = LSB first (shift-right order); sampled with `data_in`.
- in_valid  input  1  `data_in`/`dir` valid.
- in_ready  output  1  block can accept a word.
- serial_out  output  1  serial bit stream.
- serial_valid  output  1  `serial_out` carries a frame bit this cycle.
- busy  output  1  frame or gap in progress.
- done  output  1  one-cycle pulse after the last frame bit.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset is synchronous and active-high on `reset`.
  - Reset values: `serial_out`=0, `serial_valid`=0, `in_ready`=1, `busy`=0, `done`=0, state IDLE, bit counter 0, shift register 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - `in_ready`=1, `busy`=0, `serial_out`=0.
  - On an edge with `in_valid`&&`in_ready`: capture `data_in` and `dir`, clear the bit counter, go to SHIFT.
- SHIFT:
  - Cycles 1..WIDTH after acceptance: `serial_valid`=1, `serial_out`=current bit, `busy`=1, `in_ready`=0.
  - `dir`=0 → bit order data[WIDTH-1] down to data[0]; `dir`=1 → data[0] up to data[WIDTH-1].
  - All outputs are registered; first bit appears the cycle after acceptance.
- End of frame:
  - Cycle WIDTH+1: `done`=1 for exactly one cycle, `serial_valid`=0, `serial_out`=0.
  - If GAP_CYCLES=0, state is IDLE in that cycle (`in_ready`=1).
  - Otherwise state is GAP for GAP_CYCLES cycles (`busy`=1, `in_ready`=0), then IDLE.
- Back-to-back throughput: minimum spacing between frames is one idle cycle (GAP_CYCLES=0).
- `in_valid` while `in_ready`=0: ignored, no side effects. Changes to `data_in`/`dir` mid-frame do not affect the frame in flight.
- Reset mid-frame: the frame is aborted and all outputs take reset values on that edge. No `done` pulse for the aborted frame.
- Bit counter: width $clog2(WIDTH+1); it never wraps inside a frame.

Optional Feature:
- Macro: DESLOC_PARITY_EN.
- When defined:
  - One extra bit is appended after the data bits in both bit orders.
  - The extra bit is even parity, the XOR of all data bits.
  - `serial_valid` is high for WIDTH+1 cycles; `done` moves to cycle WIDTH+2.
- When undefined: frame is exactly WIDTH bits and no parity logic is present.

Decomposition:
- Package `desloc_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SHIFT`, `ST_GAP`).
  - Direction constants `DIR_MSB_FIRST`=1'b0, `DIR_LSB_FIRST`=1'b1.
  - Op-code constants `OP_HOLD`=00, `OP_SHL`=01, `OP_SHR`=10, `OP_LOAD`=11, shared with the shift register.
- Sub-module `desloc_shift_core`:
  - WIDTH-parameterised register using the four op codes above.
  - The transmitter drives `OP_LOAD` on accept, `OP_SHL`/`OP_SHR` per bit, and `OP_HOLD` otherwise.
  - Its end bit (MSB or LSB) feeds `serial_out`.

Test Plan:
- Reset held 3 cycles then released, `in_valid`=0 → `serial_out`=0, `serial_valid`=0, `in_ready`=1, `busy`=0, `done`=0.
- WIDTH=4, `data_in`=4'b1010, `dir`=0 accepted at cycle 0 → `serial_out` 1,0,1,0 on cycles 1–4 with `serial_valid`=1; `done`=1 at cycle 5 only.
- `data_in`=4'b1011, `dir`=1 → `serial_out` 1,1,0,1; then `data_in`=4'b0101 held with `in_valid`=1 during the frame → ignored until `in_ready`, accepted at cycle 5, bits on cycles 6–9.
- `reset` asserted for 1 cycle during bit 2 of 4'b1111 → next cycle `serial_valid`=0, `in_ready`=1, no `done` pulse.
- GAP_CYCLES=3 → `in_ready` stays low on cycles 5–7 after a 4-bit frame and reasserts at cycle 8.
- With DESLOC_PARITY_EN, 4'b1010 `dir`=0 → 1,0,1,0,0; 4'b1011 `dir`=0 → 1,0,1,1,1; `done` at cycle 6.
